// File: rtl/uart_sched_pkg.sv
// Shared types and frame constants for the UART command scheduler and the
// mode FSM that feeds it.
package uart_sched_pkg;

   typedef enum logic [3:0] {
      DrvStop      = 4'd0,
      DrvFwd       = 4'd1,
      DrvFwdSlow   = 4'd2,
      DrvRev       = 4'd3,
      DrvRevSlow   = 4'd4,
      DrvSoftL     = 4'd5,
      DrvSoftR     = 4'd6,
      DrvPivotL    = 4'd7,
      DrvPivotR    = 4'd8,
      DrvHardL     = 4'd9,
      DrvHardR     = 4'd10
   } drive_states_e;

   localparam logic [7:0] HDR         = 8'hA5;
   localparam logic [7:0] TYPE_DRIVE  = 8'h01;
   localparam logic [7:0] TYPE_STATUS = 8'h02;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StSend,
      StGap
   } sched_state_t;

   // Byte idx of a 4-byte frame; byte3 is the xor checksum of the first three.
   function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                             input logic [7:0] ftype,
                                             input logic [7:0] payload);
      logic [7:0] b;
      unique case (idx)
         2'd0:    b = HDR;
         2'd1:    b = ftype;
         2'd2:    b = payload;
         default: b = HDR ^ ftype ^ payload;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/interval_timer.sv
// Down-counting interval timer: pulses expire for one cycle every PERIOD
// running cycles; reload restarts the interval.
module interval_timer #(
   parameter int unsigned PERIOD = 100
) (
   input  logic clk_50,
   input  logic reset_n,
   input  logic run,
   input  logic reload,
   output logic expire
);

   localparam int unsigned CntW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CntW-1:0] CntTop = CntW'(PERIOD - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (reload) begin
         cnt_d = CntTop;
      end else if (run) begin
         cnt_d = (cnt_q == '0) ? CntTop : cnt_q - CntW'(1);
      end
   end

   assign expire = run && (cnt_q == '0);

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= CntTop;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_cmd_scheduler.sv
// Serialises drive-command and status frames onto the shared uart_tx byte
// channel; frames are atomic and arbitration happens only between frames.
module uart_cmd_scheduler
   import uart_sched_pkg::*;
#(
   parameter int unsigned KEEPALIVE_CYCLES = 5_000_000,
   parameter int unsigned STATUS_CYCLES    = 25_000_000,
   parameter int unsigned GAP_CYCLES       = 16
) (
   input  logic        clk_50,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [1:0]  state,
   input  logic [1:0]  CAM_state,
   input  logic [3:0]  drive_state,
   input  logic        state_changed,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic [15:0] frames_sent
);

   localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

   sched_state_t    fsm_q, fsm_d;
   logic [1:0]      idx_q, idx_d;
   logic [7:0]      payload_q, payload_d;
   logic [7:0]      type_q, type_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_valid_q, tx_valid_d;
   logic [15:0]     frames_q, frames_d;
   logic            drv_pend_q, drv_pend_d;
   logic            status_pend_q, status_pend_d;
   logic [3:0]      last_drive_q, last_drive_d;
   logic [GapW-1:0] gap_q, gap_d;

   logic ka_reload, ka_expire, st_expire;
   logic sel_status, load_drive, load_status, drv_set, st_set;

   interval_timer #(.PERIOD(KEEPALIVE_CYCLES)) u_keepalive (
      .clk_50  (clk_50),
      .reset_n (reset_n),
      .run     (enable),
      .reload  (ka_reload),
      .expire  (ka_expire)
   );

   interval_timer #(.PERIOD(STATUS_CYCLES)) u_status (
      .clk_50  (clk_50),
      .reset_n (reset_n),
      .run     (enable),
      .reload  (1'b0),
      .expire  (st_expire)
   );

   // Status only overtakes a pending drive frame right after a drive frame.
   assign sel_status = status_pend_q && (!drv_pend_q || (type_q == TYPE_DRIVE));

   always_comb begin
      fsm_d        = fsm_q;
      idx_d        = idx_q;
      payload_d    = payload_q;
      type_d       = type_q;
      tx_data_d    = tx_data_q;
      tx_valid_d   = tx_valid_q;
      frames_d     = frames_q;
      last_drive_d = last_drive_q;
      gap_d        = gap_q;
      ka_reload    = 1'b0;
      load_drive   = 1'b0;
      load_status  = 1'b0;

      unique case (fsm_q)
         StIdle: begin
            if (drv_pend_q || status_pend_q) fsm_d = StLoad;
         end
         StLoad: begin
            if (sel_status) begin
               type_d      = TYPE_STATUS;
               payload_d   = {state, CAM_state, drive_state};
               load_status = 1'b1;
            end else begin
               type_d       = TYPE_DRIVE;
               payload_d    = {4'h0, drive_state};
               last_drive_d = drive_state;
               ka_reload    = 1'b1;
               load_drive   = 1'b1;
            end
            idx_d      = 2'd0;
            tx_valid_d = 1'b1;
            tx_data_d  = HDR;
            fsm_d      = StSend;
         end
         StSend: begin
            if (tx_valid_q && tx_ready) begin
               if (idx_q == 2'd3) begin
                  tx_valid_d = 1'b0;
                  tx_data_d  = 8'h00;
                  frames_d   = frames_q + 16'd1;
                  gap_d      = '0;
                  fsm_d      = StGap;
               end else begin
                  idx_d     = idx_q + 2'd1;
                  tx_data_d = frame_byte(idx_q + 2'd1, type_q, payload_q);
               end
            end
         end
         StGap: begin
            if (gap_q == GapLast) fsm_d = StIdle;
            else                  gap_d = gap_q + GapW'(1);
         end
         default: fsm_d = StIdle;
      endcase

      // Compare against the value being latched so a served change is not re-raised.
      drv_set       = enable && ((drive_state != last_drive_d) || state_changed || ka_expire);
      st_set        = enable && st_expire;
      drv_pend_d    = drv_set || (drv_pend_q && !load_drive);
      status_pend_d = st_set || (status_pend_q && !load_status);
   end

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q         <= StIdle;
         idx_q         <= 2'd0;
         payload_q     <= 8'h00;
         type_q        <= TYPE_STATUS;
         tx_data_q     <= 8'h00;
         tx_valid_q    <= 1'b0;
         frames_q      <= 16'd0;
         drv_pend_q    <= 1'b1;
         status_pend_q <= 1'b0;
         last_drive_q  <= 4'd0;
         gap_q         <= '0;
      end else begin
         fsm_q         <= fsm_d;
         idx_q         <= idx_d;
         payload_q     <= payload_d;
         type_q        <= type_d;
         tx_data_q     <= tx_data_d;
         tx_valid_q    <= tx_valid_d;
         frames_q      <= frames_d;
         drv_pend_q    <= drv_pend_d;
         status_pend_q <= status_pend_d;
         last_drive_q  <= last_drive_d;
         gap_q         <= gap_d;
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign frames_sent = frames_q;
   assign busy        = (fsm_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// Directed bench for uart_cmd_scheduler: expected frame bytes are queued as
// stimulus is applied and popped as the DUT hands bytes to uart_tx.
module tb_uart_cmd_scheduler;

   logic        clk_50 = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [1:0]  state;
   logic [1:0]  CAM_state;
   logic [3:0]  drive_state;
   logic        state_changed;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic [15:0] frames_sent;

   int n_checks = 0;
   int n_fails  = 0;
   int en_edges;
   logic [7:0] exp_q[$];
   int starts[$];
   logic prev_valid = 1'b0;

   uart_cmd_scheduler #(
      .KEEPALIVE_CYCLES (100),
      .STATUS_CYCLES    (250),
      .GAP_CYCLES       (2)
   ) dut (
      .clk_50        (clk_50),
      .reset_n       (reset_n),
      .enable        (enable),
      .state         (state),
      .CAM_state     (CAM_state),
      .drive_state   (drive_state),
      .state_changed (state_changed),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .busy          (busy),
      .frames_sent   (frames_sent)
   );

   always #5 clk_50 = ~clk_50;

   // Enabled edges since reset release, i.e. how far the status timer has run.
   always @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n)    en_edges <= 0;
      else if (enable) en_edges <= en_edges + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input logic [7:0] ftype, input logic [7:0] payload);
      exp_q.push_back(8'hA5);
      exp_q.push_back(ftype);
      exp_q.push_back(payload);
      exp_q.push_back(8'hA5 ^ ftype ^ payload);
   endtask

   task automatic step();
      @(posedge clk_50);
      #1;
   endtask

   task automatic wait_frames(input logic [15:0] n, input int budget, input string tag);
      int i = 0;
      while (frames_sent !== n && i < budget) begin
         step();
         i++;
      end
      chk(tag, {16'h0, frames_sent}, {16'h0, n});
   endtask

   task automatic wait_idle(input string tag);
      int i = 0;
      while (busy !== 1'b0 && i < 50) begin
         step();
         i++;
      end
      chk(tag, {31'h0, busy}, 32'h0);
   endtask

   task automatic wait_byte(input logic [7:0] b, input string tag);
      int i = 0;
      while (!(tx_valid === 1'b1 && tx_data === b) && i < 50) begin
         step();
         i++;
      end
      chk(tag, {24'h0, tx_data}, {24'h0, b});
   endtask

   // Byte monitor: a byte counts as sent when valid and ready meet at the next edge.
   always @(negedge clk_50) begin
      if (reset_n === 1'b1) begin
         if (tx_valid === 1'b1 && prev_valid !== 1'b1) starts.push_back(en_edges);
         prev_valid <= tx_valid;
         if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fails++;
               $error("FAIL unexpected_byte: observed %0h expected none", tx_data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               assert (tx_data === e) else begin
                  n_fails++;
                  $error("FAIL tx_byte: observed %0h expected %0h", tx_data, e);
               end
            end
         end
      end else begin
         prev_valid <= 1'b0;
      end
   end

   initial begin
      reset_n       = 1'b0;
      enable        = 1'b1;
      state         = 2'd0;
      CAM_state     = 2'd0;
      drive_state   = 4'd0;
      state_changed = 1'b0;
      tx_ready      = 1'b1;
      repeat (3) @(posedge clk_50);
      #1;
      chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_frames", {16'h0, frames_sent}, 32'h0);

      // First frame after release is STOP.
      push_frame(8'h01, 8'h00);
      @(negedge clk_50);
      reset_n = 1'b1;
      wait_frames(16'd1, 40, "first_frame");
      wait_idle("idle_after_first");

      // drive_state 0->4: drv_pend after E, LOAD after E+1, header after E+2.
      push_frame(8'h01, 8'h04);
      drive_state = 4'd4;
      step();
      chk("lat_e_busy", {31'h0, busy}, 32'h0);
      chk("lat_e_valid", {31'h0, tx_valid}, 32'h0);
      step();
      chk("lat_e1_busy", {31'h0, busy}, 32'h1);
      chk("lat_e1_valid", {31'h0, tx_valid}, 32'h0);
      step();
      chk("lat_e2_valid", {31'h0, tx_valid}, 32'h1);
      chk("lat_e2_data", {24'h0, tx_data}, 32'hA5);
      wait_frames(16'd2, 40, "drive4_frame");

      // Change arrives during GAP; byte1 stalled for 5 cycles.
      push_frame(8'h01, 8'h07);
      drive_state = 4'd7;
      wait_byte(8'h01, "reach_byte1");
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_valid", {31'h0, tx_valid}, 32'h1);
         chk("stall_data", {24'h0, tx_data}, 32'h01);
      end
      tx_ready = 1'b1;
      wait_frames(16'd3, 40, "stall_frame");
      wait_idle("idle_after_stall");

      // state_changed alone re-sends the current drive command.
      push_frame(8'h01, 8'h07);
      state_changed = 1'b1;
      step();
      state_changed = 1'b0;
      wait_frames(16'd4, 40, "state_changed_frame");
      wait_idle("idle_after_sc");

      // enable=0 blocks new requests; a change mid-frame is queued, not merged.
      enable = 1'b0;
      drive_state = 4'd3;
      repeat (20) step();
      chk("disabled_frames", {16'h0, frames_sent}, 32'd4);
      chk("disabled_valid", {31'h0, tx_valid}, 32'h0);
      push_frame(8'h01, 8'h03);
      push_frame(8'h01, 8'h06);
      enable = 1'b1;
      wait_byte(8'hA5, "enabled_start");
      drive_state = 4'd6;
      wait_frames(16'd6, 60, "snapshot_frames");
      wait_idle("idle_before_reset");

      // Fresh reset: keepalives, then status/drive collision at the 250th enabled edge.
      reset_n = 1'b0;
      drive_state = 4'd0;
      state = 2'd1;
      CAM_state = 2'd2;
      exp_q.delete();
      push_frame(8'h01, 8'h00);
      push_frame(8'h01, 8'h00);
      push_frame(8'h01, 8'h00);
      push_frame(8'h02, 8'h65);
      push_frame(8'h01, 8'h05);
      @(negedge clk_50);
      starts.delete();
      reset_n = 1'b1;
      begin
         int i = 0;
         while (en_edges != 249 && i < 400) begin
            step();
            i++;
         end
         chk("reach_edge_249", en_edges, 32'd249);
      end
      drive_state = 4'd5;
      wait_frames(16'd5, 100, "collision_frames");
      chk("ka_starts_seen", {31'h0, starts.size() >= 3}, 32'h1);
      if (starts.size() >= 3) begin
         for (int k = 1; k < 3; k++) begin
            int d;
            d = starts[k] - starts[k-1];
            chk("ka_interval", {31'h0, (d >= 100 && d <= 110)}, 32'h1);
         end
      end

      // Reset while byte2 is stalled: output drops at once, restart with STOP.
      push_frame(8'h01, 8'h09);
      drive_state = 4'd9;
      wait_byte(8'h09, "reach_byte2");
      tx_ready = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("abort_valid", {31'h0, tx_valid}, 32'h0);
      chk("abort_data", {24'h0, tx_data}, 32'h0);
      chk("abort_busy", {31'h0, busy}, 32'h0);
      chk("abort_frames", {16'h0, frames_sent}, 32'h0);
      chk("abort_bytes_left", exp_q.size(), 32'd2);
      exp_q.delete();
      drive_state = 4'd0;
      tx_ready = 1'b1;
      push_frame(8'h01, 8'h00);
      @(negedge clk_50);
      reset_n = 1'b1;
      wait_frames(16'd1, 40, "restart_frame");
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
